// File: rtl/arb_pkg.sv
// Shared types and the round-robin priority search for the 16-way arbiter.
// Pure declarations and a combinational helper; no state and no flow control.
package arb_pkg;

  localparam int N    = 16;
  localparam int IDXW = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set bit scanning ptr+1, ptr+2, ... modulo N; returns 0 when req is empty.
  function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] idx;
    logic            found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = ptr + IDXW'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/onehot_dec16.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
// Purely combinational, zero latency, no flow control.
module onehot_dec16
  import arb_pkg::*;
(
  input  logic [IDXW-1:0] i_idx,
  input  logic            i_en,
  output logic [N-1:0]    o_y
);

  always_comb begin
    o_y = '0;
    if (i_en) o_y[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4to16.sv
// Round-robin arbiter, 16 requesters onto one resource, grant held until release/drop/timeout.
// Grant registered 1 cycle after req is sampled; at least one idle cycle between grants.
module rr_arbiter_4to16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_release,
  output logic [N-1:0]    o_grant,
  output logic [IDXW-1:0] o_grant_idx,
  output logic            o_grant_valid,
  output logic            o_timeout
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_idx_nxt;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_ptr_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_hold_hit;
  logic            w_owner_req;
  logic            w_revoke;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ptr     <= IDXW'(N - 1);
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  generate
    if (MAX_HOLD > 0) begin : g_hold
      logic [HCW-1:0] r_hold_cnt;

      always_ff @(posedge i_clk) begin
        if (i_rst || w_cnt_clr) begin
          r_hold_cnt <= '0;
        end else if (w_cnt_inc && (r_hold_cnt != HCW'(MAX_HOLD - 1))) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end

      assign w_hold_hit = (r_hold_cnt == HCW'(MAX_HOLD - 1));
    end else begin : g_no_hold
      assign w_hold_hit = 1'b0;
    end
  endgenerate

  assign w_owner_req = i_req[r_idx];
  assign w_revoke    = i_release || !w_owner_req || w_hold_hit;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = rr_pick(i_req, r_ptr);
          w_cnt_clr   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_revoke) begin
          w_state_nxt   = ST_IDLE;
          w_ptr_nxt     = r_idx;
          w_idx_nxt     = '0;
          // Only a pure hold-limit revoke counts as a timeout.
          w_timeout_nxt = w_hold_hit && !i_release && w_owner_req;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign o_grant_valid = (r_state == ST_GRANT);
  assign o_grant_idx   = r_idx;
  assign o_timeout     = r_timeout;

  onehot_dec16 u_dec (
    .i_idx (r_idx),
    .i_en  (o_grant_valid),
    .o_y   (o_grant)
  );

endmodule

// File: tb/tb_rr_arbiter_4to16.sv
// Table- and sequence-driven check of rr_arbiter_4to16 with a 4-cycle hold limit.
module tb_rr_arbiter_4to16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  always #5 clk = ~clk;

  rr_arbiter_4to16 #(.MAX_HOLD(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_release     (rel),
    .o_grant       (grant),
    .o_grant_idx   (grant_idx),
    .o_grant_valid (grant_valid),
    .o_timeout     (timeout)
  );

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic        ev;
    logic [3:0]  eidx;
    logic        eto;
    string       tag;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic r, input logic [15:0] q, input logic rl,
                              input logic ev, input logic [3:0] ei, input logic eto,
                              input string tag);
    vec_t v;
    v.rst = r; v.req = q; v.rel = rl; v.ev = ev; v.eidx = ei; v.eto = eto; v.tag = tag;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string tag, input string what,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h at %0t", tag, what, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare just after the rising edge.
  task automatic step(input vec_t v);
    vec_t        e;
    logic [15:0] eg;
    @(negedge clk);
    rst = v.rst; req = v.req; rel = v.rel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    eg = e.ev ? (16'h0001 << e.eidx) : 16'h0000;
    cmp(e.tag, "grant_valid", 16'(grant_valid), 16'(e.ev));
    cmp(e.tag, "grant_idx",   16'(grant_idx),   16'(e.eidx));
    cmp(e.tag, "timeout",     16'(timeout),     16'(e.eto));
    cmp(e.tag, "grant",       grant,            eg);
  endtask

  task automatic run(input logic r, input logic [15:0] q, input logic rl,
                     input logic ev, input logic [3:0] ei, input logic eto,
                     input string tag);
    vec_t v;
    v.rst = r; v.req = q; v.rel = rl; v.ev = ev; v.eidx = ei; v.eto = eto; v.tag = tag;
    step(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 16'h0000; rel = 1'b0;

    // Reset held with every requester active.
    add(1, 16'hFFFF, 0, 0, 4'd0, 0, "t1_reset0");
    add(1, 16'hFFFF, 0, 0, 4'd0, 0, "t1_reset1");
    // Rotation 0..15 then back to 0, one idle cycle after each release.
    for (int k = 0; k < 16; k++) begin
      add(0, 16'hFFFF, 0, 1, 4'(k), 0, "t2_grant");
      add(0, 16'hFFFF, 1, 0, 4'd0,  0, "t2_idle");
    end
    add(0, 16'hFFFF, 0, 1, 4'd0, 0, "t2_wrap");
    add(0, 16'hFFFF, 1, 0, 4'd0, 0, "t2_wrap_idle");
    // Owner 14 releases, then 15, 0, 1 from req 8003.
    add(0, 16'h4000, 0, 1, 4'd14, 0, "t3_own14");
    add(0, 16'h4000, 1, 0, 4'd0,  0, "t3_rel14");
    add(0, 16'h8003, 0, 1, 4'd15, 0, "t3_g15");
    add(0, 16'h8003, 1, 0, 4'd0,  0, "t3_rel15");
    add(0, 16'h8003, 0, 1, 4'd0,  0, "t3_g0");
    add(0, 16'h8003, 1, 0, 4'd0,  0, "t3_rel0");
    add(0, 16'h8003, 0, 1, 4'd1,  0, "t3_g1");
    add(0, 16'h8003, 1, 0, 4'd0,  0, "t3_rel1");
    // Owner 5 drops its request; ptr=5 makes 6 beat 5 next round.
    add(0, 16'h0020, 0, 1, 4'd5, 0, "t4_g5");
    add(0, 16'h0020, 0, 1, 4'd5, 0, "t4_hold5");
    add(0, 16'h0000, 0, 0, 4'd0, 0, "t4_drop");
    add(0, 16'h0060, 0, 1, 4'd6, 0, "t4_ptr5");
    add(0, 16'h0060, 1, 0, 4'd0, 0, "t4_rel6");

    foreach (tbl[i]) step(tbl[i]);

    // Hold limit: sole requester 0 held 4 cycles, timeout pulse, re-grant after 1 idle.
    run(0, 16'h0001, 0, 1, 4'd0, 0, "t5_g0");
    run(0, 16'h0001, 0, 1, 4'd0, 0, "t5_h1");
    run(0, 16'h0001, 0, 1, 4'd0, 0, "t5_h2");
    run(0, 16'h0001, 0, 1, 4'd0, 0, "t5_h3");
    run(0, 16'h0001, 0, 0, 4'd0, 1, "t5_timeout");
    run(0, 16'h0001, 0, 1, 4'd0, 0, "t5_regrant");
    // Non-owner bit appears mid-grant; release on the limit edge suppresses timeout.
    run(0, 16'h0003, 0, 1, 4'd0, 0, "t5b_h1");
    run(0, 16'h0003, 0, 1, 4'd0, 0, "t5b_h2");
    run(0, 16'h0003, 0, 1, 4'd0, 0, "t5b_h3");
    run(0, 16'h0003, 1, 0, 4'd0, 0, "t5b_rel_at_limit");

    // Reset mid-grant, then ptr restarts at 15 so the scan finds 9.
    run(0, 16'h0200, 0, 1, 4'd9, 0, "t6_g9");
    run(1, 16'h0200, 0, 0, 4'd0, 0, "t6_rst");
    run(0, 16'h0200, 0, 1, 4'd9, 0, "t6_g9_again");
    run(0, 16'h0200, 1, 0, 4'd0, 0, "t6_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
